// File: rtl/led_pattern_engine_if.sv
// ----------------------------------------------------------------------------
// led_pattern_engine_if
//
// Purpose : Bundles the switch/button inputs and the LED/status outputs of
//           led_pattern_engine into one interface. The board (or VIO) side
//           uses the master modport and the engine uses the slave modport.
//
// Signals :
//   i_sw      [3:0]          [0] prescaler enable, [2:1] limit select,
//                            [3] direction (0 = toward MSB, 1 = toward LSB)
//   i_button  [3:0]          [0] advance mode, [1]/[2]/[3] select R/G/B
//   o_leds    [3:0]          [0] toggles per mode advance, [3:1] colour one-hot
//   o_led_r/g/b [NB_LEDS-1:0] pattern on the selected colour, 0 elsewhere
//   o_mode    [2:0]          current pattern mode
//   o_tick                   one-cycle prescaler pulse
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

interface led_pattern_engine_if #(
    parameter int NB_LEDS = 4
);
    logic [3:0]         i_sw;
    logic [3:0]         i_button;
    logic [3:0]         o_leds;
    logic [NB_LEDS-1:0] o_led_r;
    logic [NB_LEDS-1:0] o_led_g;
    logic [NB_LEDS-1:0] o_led_b;
    logic [2:0]         o_mode;
    logic               o_tick;

    modport master (
        output i_sw,
        output i_button,
        input  o_leds,
        input  o_led_r,
        input  o_led_g,
        input  o_led_b,
        input  o_mode,
        input  o_tick
    );

    modport slave (
        input  i_sw,
        input  i_button,
        output o_leds,
        output o_led_r,
        output o_led_g,
        output o_led_b,
        output o_mode,
        output o_tick
    );
endinterface

// File: rtl/led_pattern_engine.sv
// ----------------------------------------------------------------------------
// led_pattern_engine
//
// Purpose : Parametrised LED pattern controller. Generates one of five
//           animated patterns (SHIFT, FLASH, BOUNCE, FILL, BINARY) on an
//           NB_LEDS-wide bus, paced by a programmable prescaler. Synchronised,
//           edge-detected buttons advance the mode and pick the RGB channel.
//
// Ports   :
//   clock    single rising-edge clock
//   i_reset  synchronous, active-high reset (also clears synchroniser and
//            debounce state)
//   bus      led_pattern_engine_if.slave: i_sw, i_button in; o_leds,
//            o_led_r/g/b, o_mode, o_tick out (all outputs registered)
//
// Option  : define LEDPAT_DEBOUNCE_EN to insert a per-button stability filter
//           of DEBOUNCE_CYC cycles between the synchroniser and the edge
//           detector. Without it the edge detector sees the synchroniser
//           output directly.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module led_pattern_engine #(
    parameter int              NB_LEDS      = 4,
    parameter int              NB_COUNTER   = 32,
    parameter longint unsigned LIMIT_0      = 64'd1 << (NB_COUNTER - 1),
    parameter longint unsigned LIMIT_1      = 64'd1 << (NB_COUNTER - 2),
    parameter longint unsigned LIMIT_2      = 64'd1 << (NB_COUNTER - 3),
    parameter longint unsigned LIMIT_3      = 64'd1 << (NB_COUNTER - 4),
    parameter int              DEBOUNCE_CYC = 16
) (
    input  logic                 clock,
    input  logic                 i_reset,
    led_pattern_engine_if.slave  bus
);

    typedef enum logic [2:0] {
        MODE_SHIFT  = 3'd0,
        MODE_FLASH  = 3'd1,
        MODE_BOUNCE = 3'd2,
        MODE_FILL   = 3'd3,
        MODE_BINARY = 3'd4
    } mode_e;

    localparam logic [NB_LEDS-1:0]    PAT_ONE  = NB_LEDS'(1);
    localparam logic [NB_LEDS-1:0]    PAT_ALL  = {NB_LEDS{1'b1}};
    localparam logic [NB_COUNTER-1:0] CNT_ONE  = NB_COUNTER'(1);
    // Terminal counts (LIMIT - 1) truncated to the counter width.
    localparam logic [NB_COUNTER-1:0] TERM_0   = NB_COUNTER'(LIMIT_0 - 64'd1);
    localparam logic [NB_COUNTER-1:0] TERM_1   = NB_COUNTER'(LIMIT_1 - 64'd1);
    localparam logic [NB_COUNTER-1:0] TERM_2   = NB_COUNTER'(LIMIT_2 - 64'd1);
    localparam logic [NB_COUNTER-1:0] TERM_3   = NB_COUNTER'(LIMIT_3 - 64'd1);

    if (NB_LEDS < 2 || DEBOUNCE_CYC < 1 ||
        LIMIT_0 < 2 || LIMIT_1 < 2 || LIMIT_2 < 2 || LIMIT_3 < 2) begin : g_param_check
        $error("led_pattern_engine: NB_LEDS, LIMIT_x must be >= 2 and DEBOUNCE_CYC >= 1");
    end

    // ------------------------------------------------------------------------
    // Button synchroniser and rising-edge detection
    // ------------------------------------------------------------------------
    logic [3:0] btn_meta_q;
    logic [3:0] btn_sync_q;
    logic [3:0] btn_prev_q;
    logic [3:0] btn_lvl;
    logic [3:0] btn_evt;

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge value of its source; blocking here would
    // collapse the two synchroniser stages into one.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            btn_meta_q <= '0;
            btn_sync_q <= '0;
            btn_prev_q <= '0;
        end else begin
            btn_meta_q <= bus.i_button;
            btn_sync_q <= btn_meta_q;
            btn_prev_q <= btn_lvl;
        end
    end

`ifdef LEDPAT_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);

    logic [3:0]      btn_filt_q;
    logic [DB_W-1:0] db_cnt_q [4];

    // The filtered level follows the synchronised level only after it has
    // differed for DEBOUNCE_CYC consecutive cycles; any return resets the run.
    // NOTE: this counter array is ordinary flops, not a RAM, so it is reset
    // along with everything else; a memory macro could not be cleared this way.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            btn_filt_q <= '0;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (btn_sync_q[i] == btn_filt_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
                    btn_filt_q[i] <= btn_sync_q[i];
                    db_cnt_q[i]   <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    assign btn_lvl = btn_filt_q;
`else
    assign btn_lvl = btn_sync_q;
`endif

    assign btn_evt = btn_lvl & ~btn_prev_q;

    // ------------------------------------------------------------------------
    // Prescaler, mode FSM, pattern generator and colour select
    // ------------------------------------------------------------------------
    logic [NB_COUNTER-1:0] term_cnt;
    logic [NB_COUNTER-1:0] cnt_q, cnt_d;
    logic                  tick_q, tick_d;
    mode_e                 mode_q, mode_d;
    logic [NB_LEDS-1:0]    pat_q, pat_d;
    logic                  bounce_down_q, bounce_down_d;
    logic                  flag_q, flag_d;
    logic [2:0]            col_q, col_d;     // one-hot {B, G, R}
    logic [NB_LEDS-1:0]    led_r_q, led_g_q, led_b_q;

    always_comb begin
        term_cnt = TERM_0;
        case (bus.i_sw[2:1])
            2'd0: term_cnt = TERM_0;
            2'd1: term_cnt = TERM_1;
            2'd2: term_cnt = TERM_2;
            2'd3: term_cnt = TERM_3;
            default: term_cnt = TERM_0;
        endcase
    end

    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        cnt_d         = cnt_q;
        tick_d        = 1'b0;
        mode_d        = mode_q;
        pat_d         = pat_q;
        bounce_down_d = bounce_down_q;
        flag_d        = flag_q;
        col_d         = col_q;

        // ">=" rather than "==" so shrinking the limit mid-count wraps at once
        // instead of running on to the counter's natural overflow.
        if (bus.i_sw[0]) begin
            if (cnt_q >= term_cnt) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end

        if (btn_evt[0]) begin
            // A mode advance reloads the start pattern and restarts the
            // prescaler; a tick arriving on the same edge is dropped.
            case (mode_q)
                MODE_SHIFT:  mode_d = MODE_FLASH;
                MODE_FLASH:  mode_d = MODE_BOUNCE;
                MODE_BOUNCE: mode_d = MODE_FILL;
                MODE_FILL:   mode_d = MODE_BINARY;
                default:     mode_d = MODE_SHIFT;
            endcase
            pat_d         = (mode_d == MODE_SHIFT || mode_d == MODE_BOUNCE) ? PAT_ONE : '0;
            bounce_down_d = 1'b0;
            flag_d        = ~flag_q;
            cnt_d         = '0;
            tick_d        = 1'b0;
        end else begin
            case (mode_q)
                MODE_SHIFT: if (tick_q) begin
                    pat_d = bus.i_sw[3] ? {pat_q[0], pat_q[NB_LEDS-1:1]}
                                        : {pat_q[NB_LEDS-2:0], pat_q[NB_LEDS-1]};
                end
                MODE_FLASH: if (tick_q) begin
                    pat_d = ~pat_q;
                end
                MODE_BOUNCE: if (tick_q) begin
                    // Reverse when the lit bit sits at the end it is moving toward.
                    if (!bounce_down_q) begin
                        if (pat_q[NB_LEDS-1]) begin
                            pat_d         = pat_q >> 1;
                            bounce_down_d = 1'b1;
                        end else begin
                            pat_d = pat_q << 1;
                        end
                    end else begin
                        if (pat_q[0]) begin
                            pat_d         = pat_q << 1;
                            bounce_down_d = 1'b0;
                        end else begin
                            pat_d = pat_q >> 1;
                        end
                    end
                end
                MODE_FILL: if (tick_q) begin
                    if (pat_q == PAT_ALL)  pat_d = '0;
                    else if (bus.i_sw[3])  pat_d = {1'b1, pat_q[NB_LEDS-1:1]};
                    else                   pat_d = {pat_q[NB_LEDS-2:0], 1'b1};
                end
                MODE_BINARY: if (tick_q) begin
                    pat_d = bus.i_sw[3] ? pat_q - PAT_ONE : pat_q + PAT_ONE;
                end
                default: begin
                    // Unused codes recover to SHIFT with its start pattern.
                    mode_d        = MODE_SHIFT;
                    pat_d         = PAT_ONE;
                    bounce_down_d = 1'b0;
                end
            endcase
        end

        // Colour priority R > G > B; the register only ever holds one-hot codes.
        if      (btn_evt[1]) col_d = 3'b001;
        else if (btn_evt[2]) col_d = 3'b010;
        else if (btn_evt[3]) col_d = 3'b100;
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            cnt_q         <= '0;
            tick_q        <= 1'b0;
            mode_q        <= MODE_SHIFT;
            pat_q         <= PAT_ONE;
            bounce_down_q <= 1'b0;
            flag_q        <= 1'b0;
            col_q         <= 3'b001;
            led_r_q       <= PAT_ONE;
            led_g_q       <= '0;
            led_b_q       <= '0;
        end else begin
            cnt_q         <= cnt_d;
            tick_q        <= tick_d;
            mode_q        <= mode_d;
            pat_q         <= pat_d;
            bounce_down_q <= bounce_down_d;
            flag_q        <= flag_d;
            col_q         <= col_d;
            // Colour outputs are registered from next-state values so they
            // change on the same edge as the pattern and colour registers.
            led_r_q       <= col_d[0] ? pat_d : '0;
            led_g_q       <= col_d[1] ? pat_d : '0;
            led_b_q       <= col_d[2] ? pat_d : '0;
        end
    end

    assign bus.o_leds  = {col_q, flag_q};
    assign bus.o_led_r = led_r_q;
    assign bus.o_led_g = led_g_q;
    assign bus.o_led_b = led_b_q;
    assign bus.o_mode  = mode_q;
    assign bus.o_tick  = tick_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// ----------------------------------------------------------------------------
// tb_led_pattern_engine
//
// Self-checking bench for led_pattern_engine with NB_LEDS=4, NB_COUNTER=8,
// LIMIT_0..3 = 4/8/100/2. A table of tick/button vectors walks every mode,
// then hand-written sequences cover held buttons, limit change, reset,
// mode-advance on a tick cycle and button latency.
// Inputs change and outputs are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_led_pattern_engine;

    localparam int NB_LEDS      = 4;
    localparam int DEBOUNCE_CYC = 16;
`ifdef LEDPAT_DEBOUNCE_EN
    localparam int BTN_LAT    = 3 + DEBOUNCE_CYC;
    localparam int BTN_HOLD   = DEBOUNCE_CYC + 4;
    localparam int BTN_SETTLE = DEBOUNCE_CYC + 6;
`else
    localparam int BTN_LAT    = 3;
    localparam int BTN_HOLD   = 1;
    localparam int BTN_SETTLE = 4;
`endif

    logic clock = 1'b0;
    logic i_reset;

    led_pattern_engine_if #(.NB_LEDS(NB_LEDS)) bus ();

    led_pattern_engine #(
        .NB_LEDS      (NB_LEDS),
        .NB_COUNTER   (8),
        .LIMIT_0      (4),
        .LIMIT_1      (8),
        .LIMIT_2      (100),
        .LIMIT_3      (2),
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) dut (
        .clock   (clock),
        .i_reset (i_reset),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] sw;     // switch setting for a tick vector
        logic [3:0] btn;    // nonzero: press these buttons instead of a tick
        logic [2:0] mode;
        logic [3:0] pat;
        logic [3:0] leds;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_outputs(input string name, input logic [2:0] mode,
                                 input logic [3:0] pat, input logic [3:0] leds);
        check({name, " mode"}, 32'(bus.o_mode), 32'(mode));
        check({name, " leds"}, 32'(bus.o_leds), 32'(leds));
        check({name, " r"},    32'(bus.o_led_r), 32'(leds[1] ? pat : 4'b0000));
        check({name, " g"},    32'(bus.o_led_g), 32'(leds[2] ? pat : 4'b0000));
        check({name, " b"},    32'(bus.o_led_b), 32'(leds[3] ? pat : 4'b0000));
    endtask

    // Enable the prescaler until one tick appears, freeze it, then step one
    // edge so the pattern update is visible.
    task automatic run_tick(input logic [3:0] sw, output int waited);
        bus.i_sw = sw | 4'b0001;
        waited   = 0;
        do begin
            @(negedge clock);
            waited++;
        end while (bus.o_tick !== 1'b1 && waited < 200);
        bus.i_sw = sw & 4'b1110;
        @(negedge clock);
    endtask

    task automatic press(input logic [3:0] btn, input int hold);
        bus.i_sw     = bus.i_sw & 4'b1110;
        bus.i_button = btn;
        repeat (hold) @(negedge clock);
        bus.i_button = 4'b0000;
        repeat (BTN_SETTLE) @(negedge clock);
    endtask

    function automatic void add(input logic [3:0] sw, input logic [3:0] btn,
                                input logic [2:0] mode, input logic [3:0] pat,
                                input logic [3:0] leds);
        vec_t v;
        v.sw = sw; v.btn = btn; v.mode = mode; v.pat = pat; v.leds = leds;
        vecs.push_back(v);
    endfunction

    initial begin
        int waited;
        int seen;

        i_reset      = 1'b1;
        bus.i_sw     = 4'b0000;
        bus.i_button = 4'b0000;

        //  sw       btn      mode  pat      leds
        // SHIFT up, then down
        add(4'b0001, 4'b0000, 3'd0, 4'b0010, 4'b0010);
        add(4'b0001, 4'b0000, 3'd0, 4'b0100, 4'b0010);
        add(4'b0001, 4'b0000, 3'd0, 4'b1000, 4'b0010);
        add(4'b0001, 4'b0000, 3'd0, 4'b0001, 4'b0010);
        add(4'b0001, 4'b0000, 3'd0, 4'b0010, 4'b0010);
        add(4'b0001, 4'b0000, 3'd0, 4'b0100, 4'b0010);
        add(4'b0001, 4'b0000, 3'd0, 4'b1000, 4'b0010);
        add(4'b1001, 4'b0000, 3'd0, 4'b0100, 4'b0010);
        add(4'b1001, 4'b0000, 3'd0, 4'b0010, 4'b0010);
        // FLASH
        add(4'b0000, 4'b0001, 3'd1, 4'b0000, 4'b0011);
        add(4'b0001, 4'b0000, 3'd1, 4'b1111, 4'b0011);
        add(4'b0001, 4'b0000, 3'd1, 4'b0000, 4'b0011);
        // BOUNCE, direction switch ignored
        add(4'b0000, 4'b0001, 3'd2, 4'b0001, 4'b0010);
        add(4'b1001, 4'b0000, 3'd2, 4'b0010, 4'b0010);
        add(4'b1001, 4'b0000, 3'd2, 4'b0100, 4'b0010);
        add(4'b1001, 4'b0000, 3'd2, 4'b1000, 4'b0010);
        add(4'b1001, 4'b0000, 3'd2, 4'b0100, 4'b0010);
        add(4'b1001, 4'b0000, 3'd2, 4'b0010, 4'b0010);
        add(4'b1001, 4'b0000, 3'd2, 4'b0001, 4'b0010);
        add(4'b1001, 4'b0000, 3'd2, 4'b0010, 4'b0010);
        add(4'b1001, 4'b0000, 3'd2, 4'b0100, 4'b0010);
        add(4'b1001, 4'b0000, 3'd2, 4'b1000, 4'b0010);
        add(4'b1001, 4'b0000, 3'd2, 4'b0100, 4'b0010);
        // FILL from LSB, wrap, then from MSB
        add(4'b0000, 4'b0001, 3'd3, 4'b0000, 4'b0011);
        add(4'b0001, 4'b0000, 3'd3, 4'b0001, 4'b0011);
        add(4'b0001, 4'b0000, 3'd3, 4'b0011, 4'b0011);
        add(4'b0001, 4'b0000, 3'd3, 4'b0111, 4'b0011);
        add(4'b0001, 4'b0000, 3'd3, 4'b1111, 4'b0011);
        add(4'b0001, 4'b0000, 3'd3, 4'b0000, 4'b0011);
        add(4'b1001, 4'b0000, 3'd3, 4'b1000, 4'b0011);
        add(4'b1001, 4'b0000, 3'd3, 4'b1100, 4'b0011);
        // BINARY down through zero, then up through all-ones
        add(4'b0000, 4'b0001, 3'd4, 4'b0000, 4'b0010);
        add(4'b1001, 4'b0000, 3'd4, 4'b1111, 4'b0010);
        add(4'b1001, 4'b0000, 3'd4, 4'b1110, 4'b0010);
        add(4'b0001, 4'b0000, 3'd4, 4'b1111, 4'b0010);
        add(4'b0001, 4'b0000, 3'd4, 4'b0000, 4'b0010);
        // Back to SHIFT, then colour selection and priority
        add(4'b0000, 4'b0001, 3'd0, 4'b0001, 4'b0011);
        add(4'b0000, 4'b1000, 3'd0, 4'b0001, 4'b1001);
        add(4'b0000, 4'b1010, 3'd0, 4'b0001, 4'b0011);
        add(4'b0000, 4'b1100, 3'd0, 4'b0001, 4'b0101);
        add(4'b0001, 4'b0000, 3'd0, 4'b0010, 4'b0101);
        add(4'b0000, 4'b0010, 3'd0, 4'b0010, 4'b0011);
        add(4'b1001, 4'b0000, 3'd0, 4'b0001, 4'b0011);

        repeat (3) @(negedge clock);
        check_outputs("reset", 3'd0, 4'b0001, 4'b0010);
        check("reset tick", 32'(bus.o_tick), 32'd0);
        i_reset = 1'b0;

        foreach (vecs[i]) begin
            if (vecs[i].btn != 4'b0000) begin
                press(vecs[i].btn, BTN_HOLD);
            end else begin
                run_tick(vecs[i].sw, waited);
                check($sformatf("vec%0d period", i), 32'(waited), 32'd4);
            end
            check_outputs($sformatf("vec%0d", i), vecs[i].mode, vecs[i].pat, vecs[i].leds);
        end

        // Held mode button: exactly one advance (flag toggles once).
        press(4'b0001, 100);
        check_outputs("hold b0", 3'd1, 4'b0000, 4'b0010);
        // Held green button: green selected, no stray mode events.
        press(4'b0100, 100);
        check_outputs("hold b2", 3'd1, 4'b0000, 4'b0100);

        // Prescaler disabled: no ticks.
        seen = 0;
        bus.i_sw = 4'b0100;
        repeat (20) begin
            @(negedge clock);
            if (bus.o_tick === 1'b1) seen++;
        end
        check("disabled no tick", 32'(seen), 32'd0);

        // Count to 50 with limit 100, then shrink the limit to 8.
        bus.i_sw = 4'b0101;
        repeat (50) begin
            @(negedge clock);
            if (bus.o_tick === 1'b1) seen++;
        end
        check("limit100 no tick by 50", 32'(seen), 32'd0);
        bus.i_sw = 4'b0011;
        @(negedge clock);
        check("limit shrink wrap", 32'(bus.o_tick), 32'd1);
        waited = 0;
        do begin
            @(negedge clock);
            waited++;
        end while (bus.o_tick !== 1'b1 && waited < 50);
        check("limit8 period", 32'(waited), 32'd8);
        check("flash after wrap tick", 32'(bus.o_led_g), 32'(4'b1111));
        bus.i_sw = 4'b0000;
        @(negedge clock);
        check("flash after second tick", 32'(bus.o_led_g), 32'(4'b0000));

        // Reset in the middle of running.
        bus.i_sw = 4'b0001;
        repeat (6) @(negedge clock);
        i_reset = 1'b1;
        @(negedge clock);
        check_outputs("mid reset", 3'd0, 4'b0001, 4'b0010);
        check("mid reset tick", 32'(bus.o_tick), 32'd0);
        bus.i_sw = 4'b0000;
        @(negedge clock);
        i_reset = 1'b0;

        // Mode event on the same edge as a tick: the load wins. With period 2
        // from a cleared counter, o_tick is high just before the event edge.
        bus.i_sw     = 4'b0111;
        bus.i_button = 4'b0001;
        for (int k = 1; k <= BTN_LAT; k++) begin
            @(negedge clock);
            if (k == BTN_HOLD) bus.i_button = 4'b0000;
            if (k == BTN_LAT - 1) check("coincide tick present", 32'(bus.o_tick), 32'd1);
        end
        bus.i_button = 4'b0000;
        check_outputs("coincide load", 3'd1, 4'b0000, 4'b0011);
        bus.i_sw = 4'b0000;
        repeat (BTN_SETTLE) @(negedge clock);

        // Button latency: state changes exactly BTN_LAT edges after the press.
        bus.i_button = 4'b0001;
        for (int k = 1; k <= BTN_LAT; k++) begin
            @(negedge clock);
            if (k == BTN_HOLD) bus.i_button = 4'b0000;
            if (k == BTN_LAT - 1) check("latency before", 32'(bus.o_mode), 32'd1);
        end
        bus.i_button = 4'b0000;
        check_outputs("latency edge", 3'd2, 4'b0001, 4'b0010);
        repeat (BTN_SETTLE) @(negedge clock);

`ifdef LEDPAT_DEBOUNCE_EN
        // A pulse shorter than the filter window is ignored.
        press(4'b0001, 10);
        repeat (30) @(negedge clock);
        check_outputs("short glitch", 3'd2, 4'b0001, 4'b0010);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
